joypad_ports: RTL and testbench

Responder for the CPU's controller-port strobes. It decodes `addr4016w`, `naddr4016r` and `naddr4017r` from the CPU and serves two standard 8-button controllers through 8-bit parallel-in/serial-out shift registers. Each read of $4016 or $4017 returns one button bit on D0. It sits beside the CPU on the system data bus and feeds the read-data mux whenever either read strobe is low.

---
 rtl/joypad_ports_pkg.sv | 23 ++
 rtl/joypad_shifter.sv | 58 +++++
 rtl/joypad_ports.sv | 56 +++++
 tb/tb_joypad_ports.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/joypad_ports_pkg.sv
// Shared definitions for the controller-port responder: button bit positions,
// shifter state encoding and the default open-bus value.
package joypad_ports_pkg;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam logic [7:0] OPEN_BUS_DEFAULT = 8'h40;
  localparam logic [3:0] CNT_FULL         = 4'd8;

  typedef enum logic [1:0] {
    JP_STROBE = 2'd0,
    JP_SHIFT  = 2'd1,
    JP_EMPTY  = 2'd2
  } jp_state_t;

endpackage

// File: rtl/joypad_shifter.sv
// One controller port: button synchronizer, parallel-load/serial-out register and read-edge shifting.
// Serial bit is combinational from state; a shift lands on the clock after the read strobe rises.
module joypad_shifter
  import joypad_ports_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       strobe,
  input  logic       nread,
  input  logic [7:0] buttons,
  output logic       serial
);

  logic [7:0] sync_q [SYNC_STAGES];
  logic [7:0] btn_sync;
  logic [7:0] sr;
  logic [3:0] cnt;
  logic       nread_q;
  logic       shift_evt;
  jp_state_t  state;

  assign btn_sync  = sync_q[SYNC_STAGES-1];
  assign shift_evt = ~nread_q & nread;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      sr      <= '0;
      cnt     <= '0;
      nread_q <= 1'b1;
      state   <= JP_SHIFT;
    end else begin
      sync_q[0] <= buttons;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      nread_q <= nread;

      // Reload has priority; the clock after strobe falls only leaves STROBE, so
      // a read edge coinciding with the strobe release is dropped.
      if (strobe) begin
        state <= JP_STROBE;
        sr    <= btn_sync;
        cnt   <= '0;
      end else if (state == JP_STROBE) begin
        state <= JP_SHIFT;
      end else if (shift_evt) begin
        sr <= {1'b1, sr[7:1]};
        if (cnt < CNT_FULL) cnt <= cnt + 4'd1;
        if (cnt >= CNT_FULL - 4'd1) state <= JP_EMPTY;
      end
    end
  end

  assign serial = (state == JP_STROBE) ? btn_sync[BTN_A] :
                  (state == JP_EMPTY)  ? 1'b1 : sr[0];

endmodule

// File: rtl/joypad_ports.sv
// $4016/$4017 read responder: two controller shifters plus the read-data mux.
// Read data is combinational in the strobe-low clock; no backpressure, the CPU owns bus timing.
module joypad_ports
  import joypad_ports_pkg::*;
#(
  parameter logic [7:0] OPEN_BUS    = OPEN_BUS_DEFAULT,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] addr4016w,
  input  logic       naddr4016r,
  input  logic       naddr4017r,
  input  logic [7:0] buttons1,
  input  logic [7:0] buttons2,
  output logic [7:0] data_out,
  output logic       data_valid
);

  logic serial1;
  logic serial2;
  logic nread2;
  logic unused_strobe_bits;

  assign unused_strobe_bits = ^addr4016w[2:1];

  // When both strobes are low $4016 owns the cycle, so port 2 must not see an edge.
  assign nread2 = naddr4017r | ~naddr4016r;

  joypad_shifter #(.SYNC_STAGES(SYNC_STAGES)) u_port1 (
    .clock   (clock),
    .reset   (reset),
    .strobe  (addr4016w[0]),
    .nread   (naddr4016r),
    .buttons (buttons1),
    .serial  (serial1)
  );

  joypad_shifter #(.SYNC_STAGES(SYNC_STAGES)) u_port2 (
    .clock   (clock),
    .reset   (reset),
    .strobe  (addr4016w[0]),
    .nread   (nread2),
    .buttons (buttons2),
    .serial  (serial2)
  );

  assign data_valid = ~naddr4016r | ~naddr4017r;

  always_comb begin
    data_out = 8'h00;
    if (!naddr4016r)      data_out = {OPEN_BUS[7:1], serial1};
    else if (!naddr4017r) data_out = {OPEN_BUS[7:1], serial2};
  end

endmodule

// File: tb/tb_joypad_ports.sv
// Randomized and directed bench for joypad_ports against a per-port "bit index" model.
module tb_joypad_ports;

  localparam int         SYNC  = 2;
  localparam logic [7:0] OBUS  = 8'h40;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] addr4016w = 3'b000;
  logic       naddr4016r = 1'b1;
  logic       naddr4017r = 1'b1;
  logic [7:0] buttons1 = 8'h00;
  logic [7:0] buttons2 = 8'h00;
  logic [7:0] data_out;
  logic       data_valid;

  int errors = 0;
  int checks = 0;

  // Model: latched button bytes, number of completed reads per port, strobe state.
  logic [7:0] lat [2];
  int         nrd [2];
  bit         in_strobe;

  joypad_ports #(.OPEN_BUS(OBUS), .SYNC_STAGES(SYNC)) dut (
    .clock      (clock),
    .reset      (reset),
    .addr4016w  (addr4016w),
    .naddr4016r (naddr4016r),
    .naddr4017r (naddr4017r),
    .buttons1   (buttons1),
    .buttons2   (buttons2),
    .data_out   (data_out),
    .data_valid (data_valid)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%02h expected=%02h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic model_bit(input int p);
    if (in_strobe) return (p == 0) ? buttons1[0] : buttons2[0];
    if (nrd[p] < 8) return lat[p][nrd[p]];
    return 1'b1;
  endfunction

  function automatic logic [2:0] rand_strobe(input logic s);
    logic [2:0] v;
    v = 3'($urandom);
    v[0] = s;
    return v;
  endfunction

  task automatic model_reset();
    lat[0] = 8'h00; lat[1] = 8'h00;
    nrd[0] = 0;     nrd[1] = 0;
    in_strobe = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    addr4016w = 3'b000;
    naddr4016r = 1'b1;
    naddr4017r = 1'b1;
    reset = 1'b1;
    tick();
    @(negedge clock);
    check({tag, "_dout"}, data_out, 8'h00);
    check({tag, "_vld"}, {7'd0, data_valid}, 8'h01 & 8'h00);
    reset = 1'b0;
    model_reset();
    tick();
  endtask

  // kind 0: $4016, 1: $4017, 2: both low ($4016 wins)
  task automatic read_port(input int kind, input int hold, input string tag);
    int p;
    logic [7:0] exp;
    p = (kind == 1) ? 1 : 0;
    naddr4016r = (kind == 1);
    naddr4017r = (kind == 0);
    exp = {OBUS[7:1], model_bit(p)};
    for (int c = 0; c < hold; c++) begin
      @(negedge clock);
      check(tag, data_out, exp);
      check({tag, "_vld"}, {7'd0, data_valid}, 8'h01);
      tick();
    end
    naddr4016r = 1'b1;
    naddr4017r = 1'b1;
    tick();
    if (!in_strobe && nrd[p] < 9) nrd[p]++;
  endtask

  task automatic strobe_on(input logic [7:0] b1, input logic [7:0] b2);
    buttons1 = b1;
    buttons2 = b2;
    repeat (SYNC + 1) tick();
    addr4016w = rand_strobe(1'b1);
    in_strobe = 1'b1;
    tick();
    tick();
  endtask

  task automatic strobe_off();
    addr4016w = rand_strobe(1'b0);
    tick();
    in_strobe = 1'b0;
    lat[0] = buttons1;
    lat[1] = buttons2;
    nrd[0] = 0;
    nrd[1] = 0;
  endtask

  initial begin
    model_reset();
    repeat (3) tick();
    do_reset("reset");
    @(negedge clock);
    check("idle_dout", data_out, 8'h00);

    // No strobe after reset: eight zeros, then ones.
    for (int i = 0; i < 10; i++) read_port(0, 1, "nostrobe");

    // A, Select, Right pressed.
    strobe_on(8'b1000_0101, 8'h00);
    strobe_off();
    for (int i = 0; i < 9; i++) read_port(0, 1, "seq1");

    // Strobe held: live A button, reads never advance.
    strobe_on(8'h01, 8'h00);
    for (int i = 0; i < 3; i++) read_port(0, 1, "live");
    buttons1 = 8'h00;
    repeat (SYNC) tick();
    read_port(0, 1, "live_drop");
    strobe_off();

    // Interleaved port reads.
    strobe_on(8'h00, 8'h02);
    strobe_off();
    read_port(1, 1, "p2_a");
    read_port(0, 1, "p1_a");
    read_port(1, 1, "p2_b");

    // Multi-cycle read shifts once.
    strobe_on(8'b0000_0110, 8'h00);
    strobe_off();
    read_port(0, 3, "long");
    read_port(0, 1, "after_long");

    // Both low: port 1 answers and only port 1 advances.
    strobe_on(8'h01, 8'h01);
    strobe_off();
    read_port(2, 1, "both");
    read_port(1, 1, "p2_untouched");

    // Read edge coinciding with strobe release is dropped by the reload.
    strobe_on(8'h01, 8'h00);
    naddr4016r = 1'b0;
    @(negedge clock);
    check("edge_rel_live", data_out, {OBUS[7:1], 1'b1});
    tick();
    naddr4016r = 1'b1;
    addr4016w = rand_strobe(1'b0);
    tick();
    in_strobe = 1'b0;
    lat[0] = buttons1; lat[1] = buttons2;
    nrd[0] = 0; nrd[1] = 0;
    read_port(0, 1, "edge_rel_b0");
    read_port(0, 1, "edge_rel_b1");

    // Reset mid-sequence.
    strobe_on(8'hFF, 8'hFF);
    strobe_off();
    for (int i = 0; i < 3; i++) read_port(0, 1, "pre_rst");
    do_reset("midreset");
    for (int i = 0; i < 9; i++) read_port(0, 1, "post_rst");

    // Random sequences.
    for (int it = 0; it < 40; it++) begin
      int n;
      if ($urandom_range(0, 7) == 0) do_reset("rnd_reset");
      strobe_on(8'($urandom), 8'($urandom));
      if ($urandom_range(0, 3) == 0) read_port(int'($urandom_range(0, 2)), 1, "rnd_live");
      strobe_off();
      n = int'($urandom_range(0, 12));
      for (int r = 0; r < n; r++)
        read_port(int'($urandom_range(0, 2)), int'($urandom_range(1, 3)), "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
